puzzle_loader: RTL and testbench

- Serial board-configuration receiver that writes the 4x4 cell grid, in the opposite direction to the VGA path that reads it.
- Receives 8N1 UART frames from a host and assembles a 32-bit board image in the same packing as display_state: 2 bits per cell, cell 0 at [1:0], row 1 in [7:0].
- Validates the image, then presents it with a one-cycle strobe that drives the cells' load inputs. Sits beside the row/column input logic in the top level.

---
 rtl/puzzle_loader.sv | 207 ++++++++++++++++++++
 tb/tb_puzzle_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/puzzle_loader.sv
// UART board-configuration receiver: collects header + 4 payload bytes + XOR checksum
// and presents the validated 4x4 board image with a one-cycle load strobe.
module puzzle_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        busy,
    output logic        frame_error,
    output logic        checksum_error
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_M1  = TMO_W'(TMO_LIMIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {FRM_HUNT, FRM_PAYLOAD, FRM_CHECK} frm_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done, stop_err;

    frm_state_t       frm_state_q, frm_state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       xor_q, xor_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout;
    logic [31:0]      load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             busy_q, busy_d;
    logic             frame_error_q, frame_error_d;
    logic             checksum_error_q, checksum_error_d;

    // Byte receiver: byte_done / stop_err are asserted in the stop-bit sample cycle
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        stop_err   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_done  = rx_sync_q;
                    stop_err   = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // The inter-byte timer only runs while the line sits idle inside a frame
    assign timeout = (frm_state_q != FRM_HUNT) && (rx_state_q == RX_IDLE) && (tmo_q == TMO_M1);

    always_comb begin
        frm_state_d      = frm_state_q;
        idx_d            = idx_q;
        shadow_d         = shadow_q;
        xor_d            = xor_q;
        load_data_d      = load_data_q;
        load_valid_d     = 1'b0;
        busy_d           = busy_q;
        frame_error_d    = 1'b0;
        checksum_error_d = 1'b0;

        if (frm_state_q == FRM_HUNT || byte_done)
            tmo_d = '0;
        else if (rx_state_q == RX_IDLE)
            tmo_d = tmo_q + TMO_W'(1);
        else
            tmo_d = tmo_q;

        case (frm_state_q)
            FRM_HUNT: begin
                if (byte_done && shift_q == HEADER) begin
                    frm_state_d = FRM_PAYLOAD;
                    idx_d       = '0;
                    xor_d       = '0;
                    busy_d      = 1'b1;
                end
            end
            FRM_PAYLOAD: begin
                if (stop_err || timeout) begin
                    frm_state_d   = FRM_HUNT;
                    busy_d        = 1'b0;
                    frame_error_d = 1'b1;
                end else if (byte_done) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = shift_q;
                    xor_d = xor_q ^ shift_q;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) frm_state_d = FRM_CHECK;
                end
            end
            FRM_CHECK: begin
                if (stop_err || timeout) begin
                    frm_state_d   = FRM_HUNT;
                    busy_d        = 1'b0;
                    frame_error_d = 1'b1;
                end else if (byte_done) begin
                    frm_state_d = FRM_HUNT;
                    busy_d      = 1'b0;
                    if (shift_q == xor_q) begin
                        load_data_d  = shadow_q;
                        load_valid_d = 1'b1;
                    end else begin
                        checksum_error_d = 1'b1;
                    end
                end
            end
            default: begin
                frm_state_d = FRM_HUNT;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q        <= 1'b1;
            rx_sync_q        <= 1'b1;
            rx_prev_q        <= 1'b1;
            rx_state_q       <= RX_IDLE;
            cnt_q            <= '0;
            bit_idx_q        <= '0;
            frm_state_q      <= FRM_HUNT;
            idx_q            <= '0;
            tmo_q            <= '0;
            load_data_q      <= '0;
            load_valid_q     <= 1'b0;
            busy_q           <= 1'b0;
            frame_error_q    <= 1'b0;
            checksum_error_q <= 1'b0;
        end else begin
            rx_meta_q        <= rx;
            rx_sync_q        <= rx_meta_q;
            rx_prev_q        <= rx_sync_q;
            rx_state_q       <= rx_state_d;
            cnt_q            <= cnt_d;
            bit_idx_q        <= bit_idx_d;
            frm_state_q      <= frm_state_d;
            idx_q            <= idx_d;
            tmo_q            <= tmo_d;
            load_data_q      <= load_data_d;
            load_valid_q     <= load_valid_d;
            busy_q           <= busy_d;
            frame_error_q    <= frame_error_d;
            checksum_error_q <= checksum_error_d;
        end
    end

    // Datapath registers: always rewritten before use, so they carry no reset
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        shadow_q <= shadow_d;
        xor_q    <= xor_d;
    end

    assign load_data      = load_data_q;
    assign load_valid     = load_valid_q;
    assign busy           = busy_q;
    assign frame_error    = frame_error_q;
    assign checksum_error = checksum_error_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Directed bench for puzzle_loader with CLKS_PER_BIT=16: good/bad frames, glitches,
// stop-bit errors, inter-byte timeout and mid-frame reset.
module tb_puzzle_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [31:0] load_data;
    logic        load_valid, busy, frame_error, checksum_error;

    int          total = 0, bad = 0;
    int          n_lv = 0, n_fe = 0, n_ce = 0;
    logic [31:0] lv_data = '0;
    logic        busy_at_lv = 1'b1;

    always #5 clk = ~clk;

    puzzle_loader #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5), .TIMEOUT_BITS(40)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .load_data(load_data), .load_valid(load_valid), .busy(busy),
        .frame_error(frame_error), .checksum_error(checksum_error)
    );

    // Pulse counters: a strobe longer than one cycle shows up as an extra count
    always @(negedge clk) begin
        if (load_valid) begin
            n_lv       <= n_lv + 1;
            lv_data    <= load_data;
            busy_at_lv <= busy;
        end
        if (frame_error)    n_fe <= n_fe + 1;
        if (checksum_error) n_ce <= n_ce + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        send_byte(cs, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_load_data", load_data, 32'h0);
        check_val("rst_flags", {28'h0, load_valid, busy, frame_error, checksum_error}, 32'h0);
        reset = 1'b0;
        idle_bits(2);

        // Bad checksum straight after reset
        send_frame(8'h1B, 8'hE4, 8'h00, 8'hFF, 8'h01);
        idle_bits(2);
        check_val("badcs_ce", n_ce, 1);
        check_val("badcs_lv", n_lv, 0);
        check_val("badcs_data", load_data, 32'h0);
        check_val("badcs_busy", busy, 0);
        check_val("badcs_fe", n_fe, 0);

        // Good frame
        send_byte(8'hA5, 1'b1);
        check_val("good_busy_hdr", busy, 1);
        send_byte(8'h1B, 1'b1);
        send_byte(8'hE4, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(2);
        check_val("good_lv", n_lv, 1);
        check_val("good_lv_data", lv_data, 32'hFF00E41B);
        check_val("good_data", load_data, 32'hFF00E41B);
        check_val("good_busy_at_lv", busy_at_lv, 0);
        check_val("good_errs", n_fe + n_ce, 1);

        // Glitch, junk bytes, then a frame
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(3);
        check_val("glitch_busy", busy, 0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h77, 1'b1);
        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
        idle_bits(2);
        check_val("junk_lv", n_lv, 2);
        check_val("junk_data", load_data, 32'h78563412);
        check_val("junk_errs", n_fe * 16 + n_ce, 1);

        // Stop-bit error on payload byte 2
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        idle_bits(2);
        check_val("stop_fe", n_fe, 1);
        check_val("stop_busy", busy, 0);
        check_val("stop_lv", n_lv, 2);
        send_frame(8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h00);
        idle_bits(2);
        check_val("stop_recover_lv", n_lv, 3);
        check_val("stop_recover_data", load_data, 32'hF00F55AA);

        // Idle gap in HUNT, then inter-byte timeout inside a frame
        idle_bits(41);
        check_val("hunt_gap_fe", n_fe, 1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle_bits(38);
        check_val("tmo_early_fe", n_fe, 1);
        check_val("tmo_early_busy", busy, 1);
        idle_bits(3);
        check_val("tmo_fe", n_fe, 2);
        check_val("tmo_busy", busy, 0);

        // Reset in the middle of payload byte 3
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (4 * CPB) @(negedge clk);
                @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1;
                check_val("midrst_data", load_data, 32'h0);
                check_val("midrst_flags", {28'h0, load_valid, busy, frame_error, checksum_error}, 32'h0);
                reset = 1'b0;
            end
        join
        send_byte(8'hFC, 1'b1);
        idle_bits(2);
        check_val("midrst_lv", n_lv, 3);
        check_val("midrst_errs", n_fe * 16 + n_ce, 33);
        check_val("midrst_hold", load_data, 32'h0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        idle_bits(2);
        check_val("after_rst_lv", n_lv, 4);
        check_val("after_rst_data", load_data, 32'h04030201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
